dqn_train_seq: RTL and testbench
================================

Name: dqn_train_seq

Overview:
- Training-step sequencer for the DQN datapath.
- On each `start` it walks three phases over the layer blocks: forward pass (layers 1..3), loss, and backward pass (layers 3..1).
- Every BATCH-th step it also runs a parameter-update phase that asserts the update code on `ctrl`. The bias3 and weight blocks add their deltas only in that phase.
- It drives the shared `ctrl`/`step`/`sel` bus that all layer blocks decode.

Parameters:
- NUM_LAYERS, 3, number of layers sequenced (1..4).
- BATCH, 4, training steps per parameter update (1..65535).
- TIMEOUT, 1023, max cycles to wait for `layer_done` before error (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin one training step; sampled only in IDLE.
- abort  in  1  return to IDLE next cycle from any state.
- layer_done  in  1  one-cycle pulse from the addressed layer: current operation complete.
- ctrl  out  4  phase code: 0000 idle, 0001 forward, 0010 backward, 0011 update, 0100 loss.
- step  out  4  current layer index, 1..NUM_LAYERS; 0 in IDLE, LOSS, DONE.
- sel  out  4  one-hot layer select, bit (step-1); 0000 when step=0.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on step completion.
- updated  out  1  one-cycle pulse together with `done` when the step included UPD.
- err  out  1  sticky timeout flag; cleared only by rst.
- iter_cnt  out  16  completed training steps, wraps at 2^16.

Behaviour:
- Reset values (all registered outputs):
  - ctrl=0000, step=0, sel=0000.
  - busy=0, done=0, updated=0, err=0, iter_cnt=0.
  - Internal batch counter bcnt=0; state IDLE.
- FSM states: IDLE, FWD, LOSS, BWD, UPD, DONE.
- IDLE:
  - start=1 → FWD with step=1, ctrl=0001 on the next cycle.
  - start while busy is ignored; no queuing.
- FWD: on layer_done, if step<NUM_LAYERS then step+1; else → LOSS.
- LOSS: ctrl=0100, waits one layer_done from the loss unit, then → BWD with step=NUM_LAYERS, ctrl=0010.
- BWD: on layer_done, if step>1 then step-1; else exit:
  - If bcnt==BATCH-1 → UPD, step=1, bcnt←0.
  - Otherwise → DONE, bcnt←bcnt+1.
- UPD:
  - ctrl=0011 with sel one-hot, held exactly one cycle per layer; no layer_done is expected.
  - step advances 1..NUM_LAYERS on consecutive cycles, so the phase lasts exactly NUM_LAYERS cycles.
  - Then → DONE.
- DONE:
  - Single cycle: done=1, updated=1 if UPD ran this step, iter_cnt+1.
  - ctrl=0000, step=0, sel=0000. Next state IDLE.
- Output timing: ctrl/step/sel are registered and change on the same edge as the state change, so layers see them one cycle after the transition decision.
- layer_done rules:
  - Accepted only in FWD/LOSS/BWD; ignored in IDLE, UPD and DONE.
  - A pulse on the same cycle the state is entered is accepted.
- Watchdog:
  - Counter cleared on every state/step change; counts while waiting in FWD/LOSS/BWD.
  - On reaching TIMEOUT without layer_done: err←1 and → IDLE.
  - No done pulse, iter_cnt and bcnt unchanged.
- abort:
  - Any state → IDLE on the next edge; outputs return to their IDLE values.
  - bcnt and iter_cnt are unchanged and no done pulse is produced.
  - abort has priority over layer_done and start in the same cycle.
- rst: mid-operation reset returns all outputs and counters to reset values on the next edge; rst has priority over abort.
- Parameter edge cases:
  - BATCH=1: every step runs UPD.
  - NUM_LAYERS=1: FWD and BWD each take one layer_done.
- iter_cnt wraps 65535→0 with no flag.

Test Plan:
- Basic step (NUM_LAYERS=3, BATCH=4): rst, start, layer_done 3 cycles after each step change → ctrl sequence 0001(step 1,2,3), 0100, 0010(step 3,2,1), then done=1, updated=0, iter_cnt=1.
- Update cadence: run 4 steps → 4th step shows ctrl=0011 with sel=0001, 0010, 0100 on 3 consecutive cycles, then done=1 with updated=1. bcnt returns to 0; the 8th step updates again.
- Timeout (TIMEOUT=15): start, withhold layer_done in FWD step 2 → after 15 cycles err=1, state IDLE, busy=0, iter_cnt unchanged. A following start still runs normally with err staying 1.
- Abort/priority: assert abort and layer_done together in BWD step 2 → IDLE next cycle, ctrl=0000, no done. start+abort in IDLE → remains IDLE.
- Spurious inputs: layer_done pulses in IDLE/UPD and start while busy → no state change. Synchronous rst in UPD → next cycle all outputs 0, iter_cnt=0.
- Wrap: preload via 65535 completed steps (or force) → next done gives iter_cnt=0.

Source files
------------

// File: rtl/dqn_train_seq_if.sv
// Sequencer bus: start/abort/layer_done in, phase code and status out.
// Latency: none, this is wiring only.
// Backpressure: none, the sequencer paces itself on layer_done.
interface dqn_train_seq_if;
   logic        start;
   logic        abort;
   logic        layer_done;
   logic [3:0]  ctrl;
   logic [3:0]  step;
   logic [3:0]  sel;
   logic        busy;
   logic        done;
   logic        updated;
   logic        err;
   logic [15:0] iter_cnt;

   // Sequencer side
   modport master (
      input  start, abort, layer_done,
      output ctrl, step, sel, busy, done, updated, err, iter_cnt
   );

   // Controller / layer side
   modport slave (
      output start, abort, layer_done,
      input  ctrl, step, sel, busy, done, updated, err, iter_cnt
   );
endinterface

// File: rtl/dqn_train_seq.sv
// Training-step sequencer: FWD 1..N, LOSS, BWD N..1, UPD every BATCH-th step, then DONE.
// Latency: ctrl/step/sel registered, valid one cycle after each transition decision.
// Backpressure: waits for layer_done in FWD/LOSS/BWD; a watchdog drops to IDLE with sticky err.
module dqn_train_seq #(
   parameter int NUM_LAYERS = 3,
   parameter int BATCH      = 4,
   parameter int TIMEOUT    = 1023
) (
   input  logic            clk,
   input  logic            rst,
   dqn_train_seq_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_FWD,
      S_LOSS,
      S_BWD,
      S_UPD,
      S_DONE
   } state_t;

   localparam logic [3:0] C_IDLE = 4'b0000;
   localparam logic [3:0] C_FWD  = 4'b0001;
   localparam logic [3:0] C_BWD  = 4'b0010;
   localparam logic [3:0] C_UPD  = 4'b0011;
   localparam logic [3:0] C_LOSS = 4'b0100;

   // Watchdog counts 0..TIMEOUT-1 while waiting; the TIMEOUT-th idle cycle trips it.
   localparam int          WW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [WW-1:0] WLAST  = WW'(TIMEOUT - 1);
   localparam logic [3:0]  LAST     = 4'(NUM_LAYERS);
   localparam logic [3:0]  LAST_SEL = 4'(1 << (NUM_LAYERS - 1));
   localparam logic [15:0] BLAST    = 16'(BATCH - 1);

   state_t        state;
   logic [3:0]    ctrl_q;
   logic [3:0]    step_q;
   logic [3:0]    sel_q;
   logic          busy_q;
   logic          done_q;
   logic          upd_q;
   logic          err_q;
   logic [15:0]   iter_q;
   logic [15:0]   bcnt;
   logic [WW-1:0] wdog;
   logic          waiting;

   // States that consume layer_done and are covered by the watchdog
   assign waiting = (state == S_FWD) || (state == S_LOSS) || (state == S_BWD);

   assign bus.ctrl     = ctrl_q;
   assign bus.step     = step_q;
   assign bus.sel      = sel_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.updated  = upd_q;
   assign bus.err      = err_q;
   assign bus.iter_cnt = iter_q;

   // Phase FSM with registered bus outputs, batch/iteration counters and watchdog
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         ctrl_q <= C_IDLE;
         step_q <= '0;
         sel_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         upd_q  <= 1'b0;
         err_q  <= 1'b0;
         iter_q <= '0;
         bcnt   <= '0;
         wdog   <= '0;
      end else begin
         // done/updated are single-cycle pulses; watchdog restarts on any progress
         done_q <= 1'b0;
         upd_q  <= 1'b0;
         wdog   <= '0;
         if (bus.abort) begin
            state  <= S_IDLE;
            ctrl_q <= C_IDLE;
            step_q <= '0;
            sel_q  <= '0;
            busy_q <= 1'b0;
         end else if (waiting && !bus.layer_done) begin
            if (wdog == WLAST) begin
               err_q  <= 1'b1;
               state  <= S_IDLE;
               ctrl_q <= C_IDLE;
               step_q <= '0;
               sel_q  <= '0;
               busy_q <= 1'b0;
            end else begin
               wdog <= wdog + 1'b1;
            end
         end else begin
            // From here on, a waiting state has its layer_done
            case (state)
               S_IDLE: begin
                  if (bus.start) begin
                     state  <= S_FWD;
                     ctrl_q <= C_FWD;
                     step_q <= 4'd1;
                     sel_q  <= 4'b0001;
                     busy_q <= 1'b1;
                  end
               end
               S_FWD: begin
                  if (step_q < LAST) begin
                     step_q <= step_q + 4'd1;
                     sel_q  <= sel_q << 1;
                  end else begin
                     state  <= S_LOSS;
                     ctrl_q <= C_LOSS;
                     step_q <= '0;
                     sel_q  <= '0;
                  end
               end
               S_LOSS: begin
                  state  <= S_BWD;
                  ctrl_q <= C_BWD;
                  step_q <= LAST;
                  sel_q  <= LAST_SEL;
               end
               S_BWD: begin
                  if (step_q > 4'd1) begin
                     step_q <= step_q - 4'd1;
                     sel_q  <= sel_q >> 1;
                  end else if (bcnt == BLAST) begin
                     // Last step of the batch: walk the update phase over every layer
                     state  <= S_UPD;
                     ctrl_q <= C_UPD;
                     step_q <= 4'd1;
                     sel_q  <= 4'b0001;
                     bcnt   <= '0;
                  end else begin
                     state  <= S_DONE;
                     ctrl_q <= C_IDLE;
                     step_q <= '0;
                     sel_q  <= '0;
                     bcnt   <= bcnt + 16'd1;
                     done_q <= 1'b1;
                     iter_q <= iter_q + 16'd1;
                  end
               end
               S_UPD: begin
                  // One cycle per layer, no handshake from the layers
                  if (step_q < LAST) begin
                     step_q <= step_q + 4'd1;
                     sel_q  <= sel_q << 1;
                  end else begin
                     state  <= S_DONE;
                     ctrl_q <= C_IDLE;
                     step_q <= '0;
                     sel_q  <= '0;
                     done_q <= 1'b1;
                     upd_q  <= 1'b1;
                     iter_q <= iter_q + 16'd1;
                  end
               end
               S_DONE: begin
                  state  <= S_IDLE;
                  busy_q <= 1'b0;
               end
               default: begin
                  state  <= S_IDLE;
                  ctrl_q <= C_IDLE;
                  step_q <= '0;
                  sel_q  <= '0;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end
endmodule

// File: tb/tb_dqn_train_seq.sv
// Bench for dqn_train_seq: random layer_done timing, spurious inputs, abort, timeout, reset and wrap.
// Latency: expected bus snapshots are stamped with the cycle they must appear in.
// Backpressure: the bench plays the layer blocks and paces layer_done itself.
module tb_dqn_train_seq;
   localparam int NL  = 3;
   localparam int BAT = 4;
   localparam int TMO = 15;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [3:0]  step;
      logic [3:0]  sel;
      logic        busy;
      logic        done;
      logic        updated;
      logic        err;
      logic [15:0] iter;
   } obs_t;

   typedef struct {
      obs_t o;
      int   cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   dqn_train_seq_if bus ();

   dqn_train_seq #(.NUM_LAYERS(NL), .BATCH(BAT), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   exp_t        q[$];
   int          cyc     = 0;
   int          n_cmp   = 0;
   int          n_fail  = 0;
   bit          mon_en  = 0;
   logic        err_m   = 0;
   logic [15:0] iter_m  = 0;
   int          bcnt_m  = 0;

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expected bus view for a phase code / layer index, using the model's status
   function automatic obs_t mk(input logic [3:0] c, input logic [3:0] s,
                               input logic b, input logic d, input logic u);
      obs_t o;
      o.ctrl    = c;
      o.step    = s;
      o.sel     = (s == 4'd0) ? 4'b0000 : 4'(32'd1 << (s - 4'd1));
      o.busy    = b;
      o.done    = d;
      o.updated = u;
      o.err     = err_m;
      o.iter    = iter_m;
      return o;
   endfunction

   function automatic void push(input obs_t o);
      exp_t e;
      e.o   = o;
      e.cyc = cyc;
      q.push_back(e);
   endfunction

   // Drive one cycle of inputs, then step past the next rising edge
   task automatic cycle(input bit s, input bit ld, input bit ab);
      bus.start      = s;
      bus.layer_done = ld;
      bus.abort      = ab;
      @(posedge clk);
      #1;
      cyc++;
      bus.start      = 1'b0;
      bus.layer_done = 1'b0;
      bus.abort      = 1'b0;
   endtask

   function automatic int pick_delay();
      if ($urandom_range(0, 7) == 0) return TMO - 1;
      return $urandom_range(0, 3);
   endfunction

   // One training step as the layers see it; optional abort / timeout phase, or reset in UPD
   task automatic run_step(input int abort_ph, input int tmo_ph, input bit rst_upd);
      logic [3:0] c;
      logic [3:0] s;
      bit         up;
      int         d;
      cycle(1'b1, 1'b0, 1'b0);
      for (int ph = 0; ph < 2 * NL + 1; ph++) begin
         if (ph < NL) begin
            c = 4'd1; s = 4'(ph + 1);
         end else if (ph == NL) begin
            c = 4'd4; s = 4'd0;
         end else begin
            c = 4'd2; s = 4'(2 * NL + 1 - ph);
         end
         push(mk(c, s, 1'b1, 1'b0, 1'b0));
         if (ph == abort_ph) begin
            d = $urandom_range(0, 3);
            repeat (d) cycle(rb(), 1'b0, 1'b0);
            cycle(rb(), 1'b1, 1'b1);
            push(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
            return;
         end
         if (ph == tmo_ph) begin
            repeat (TMO) cycle(rb(), 1'b0, 1'b0);
            err_m = 1'b1;
            push(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
            return;
         end
         d = pick_delay();
         repeat (d) cycle(rb(), 1'b0, 1'b0);
         cycle(rb(), 1'b1, 1'b0);
      end
      up = (bcnt_m == BAT - 1);
      if (up) begin
         bcnt_m = 0;
         for (int l = 1; l <= NL; l++) begin
            push(mk(4'd3, 4'(l), 1'b1, 1'b0, 1'b0));
            if (rst_upd && l == NL) begin
               rst = 1'b1;
               cycle(rb(), rb(), 1'b0);
               rst    = 1'b0;
               err_m  = 1'b0;
               iter_m = 16'd0;
               bcnt_m = 0;
               push(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
               return;
            end
            cycle(rb(), rb(), 1'b0);
         end
      end else begin
         bcnt_m++;
      end
      iter_m = iter_m + 16'd1;
      push(mk(4'd0, 4'd0, 1'b1, 1'b1, up));
      cycle(rb(), rb(), 1'b0);
      push(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
   endtask

   task automatic idle_gap();
      int n;
      n = $urandom_range(0, 2);
      repeat (n) cycle(1'b0, rb(), 1'b0);
   endtask

   // Monitor: every change of the bus view must match the next expected snapshot and cycle
   obs_t prev;
   bit   started = 0;
   always @(negedge clk) begin
      obs_t cur;
      exp_t e;
      cur = '{bus.ctrl, bus.step, bus.sel, bus.busy, bus.done, bus.updated, bus.err, bus.iter_cnt};
      if (mon_en && (!started || cur != prev)) begin
         started = 1;
         n_cmp++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_change cyc=%0d got ctrl=%b step=%0d sel=%b busy=%b done=%b upd=%b err=%b iter=%0d",
                     cyc, cur.ctrl, cur.step, cur.sel, cur.busy, cur.done, cur.updated, cur.err, cur.iter);
         end else begin
            e = q.pop_front();
            if (e.o !== cur || e.cyc != cyc) begin
               n_fail++;
               $display("FAIL bus_view cyc=%0d got ctrl=%b step=%0d sel=%b busy=%b done=%b upd=%b err=%b iter=%0d | want cyc=%0d ctrl=%b step=%0d sel=%b busy=%b done=%b upd=%b err=%b iter=%0d",
                        cyc, cur.ctrl, cur.step, cur.sel, cur.busy, cur.done, cur.updated, cur.err, cur.iter,
                        e.cyc, e.o.ctrl, e.o.step, e.o.sel, e.o.busy, e.o.done, e.o.updated, e.o.err, e.o.iter);
            end
         end
      end
      prev = cur;
   end

   initial begin
      bus.start      = 1'b0;
      bus.layer_done = 1'b0;
      bus.abort      = 1'b0;
      rst            = 1'b1;
      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      push(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
      mon_en = 1;
      rst    = 1'b0;
      cycle(1'b0, 1'b1, 1'b0);

      // Two full batches: steps 4 and 8 run the update phase
      for (int i = 0; i < 2 * BAT; i++) begin
         run_step(-1, -1, 1'b0);
         idle_gap();
      end

      // Watchdog in FWD step 2, then a normal step with err held
      run_step(-1, 1, 1'b0);
      run_step(-1, -1, 1'b0);

      // Abort together with layer_done in BWD step 2
      run_step(2 * NL - 1, -1, 1'b0);

      // start and abort together in IDLE: nothing happens
      cycle(1'b1, 1'b0, 1'b1);
      cycle(1'b0, 1'b1, 1'b0);

      // Random mix of clean steps, aborts and timeouts
      for (int i = 0; i < 20; i++) begin
         case ($urandom_range(0, 9))
            0:       run_step($urandom_range(0, 2 * NL), -1, 1'b0);
            1:       run_step(-1, $urandom_range(0, 2 * NL), 1'b0);
            default: run_step(-1, -1, 1'b0);
         endcase
         idle_gap();
      end

      // Reset during the update phase
      while (bcnt_m != BAT - 1) run_step(-1, -1, 1'b0);
      run_step(-1, -1, 1'b1);
      cycle(1'b0, 1'b0, 1'b0);
      run_step(-1, -1, 1'b0);

      // Iteration counter wrap from 65535
      cycle(1'b0, 1'b0, 1'b0);
      force dut.iter_q = 16'hFFFF;
      iter_m = 16'hFFFF;
      push(mk(4'd0, 4'd0, 1'b0, 1'b0, 1'b0));
      cycle(1'b0, 1'b0, 1'b0);
      release dut.iter_q;
      cycle(1'b0, 1'b0, 1'b0);
      run_step(-1, -1, 1'b0);

      cycle(1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL pending_expected left=%0d required=0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
